// File: rtl/axis_nn_pkg.sv
// Shared definitions for the AXI4-Stream NN frame wrapper: one-hot FSM
// encodings, m_axis_user bit positions and a constant clog2 helper.
package axis_nn_pkg;

    // One-hot state encodings, kept as plain constants for legacy tools.
    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_LOAD  = 5'b00010;
    localparam logic [4:0] ST_DRAIN = 5'b00100;
    localparam logic [4:0] ST_EXEC  = 5'b01000;
    localparam logic [4:0] ST_SEND  = 5'b10000;

    // Bit positions inside m_axis_user.
    localparam int USER_OVF = 0;
    localparam int USER_TMO = 1;

    // Bits needed to encode values 0 .. value-1 (minimum 0).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_nn_frame_wrapper_if.sv
// Stream-side signals of the NN frame wrapper. The slave modport is the
// wrapper's view (it sinks s_axis and sources m_axis); master is the
// environment's view.
interface axis_nn_frame_wrapper_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 4
);
    logic                  s_axis_valid;
    logic [DATA_WIDTH-1:0] s_axis_data;
    logic                  s_axis_last;
    logic                  s_axis_ready;

    logic                  m_axis_valid;
    logic [OUT_WIDTH-1:0]  m_axis_data;
    logic [1:0]            m_axis_user;
    logic                  m_axis_last;
    logic                  m_axis_ready;

    modport slave (
        input  s_axis_valid, s_axis_data, s_axis_last, m_axis_ready,
        output s_axis_ready, m_axis_valid, m_axis_data, m_axis_user, m_axis_last
    );

    modport master (
        output s_axis_valid, s_axis_data, s_axis_last, m_axis_ready,
        input  s_axis_ready, m_axis_valid, m_axis_data, m_axis_user, m_axis_last
    );
endinterface

// File: rtl/axis_nn_frame_buffer.sv
// Image buffer for one input frame: write pointer, per-word writes, clear
// after a result is delivered, and the IMG_BITS view handed to the core.
// Bits of the frame above IMG_BITS are never observed, so they are not stored.
module axis_nn_frame_buffer
    import axis_nn_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int NUMBER_OF_INPUT_WORDS = 32,
    parameter int IMG_BITS              = 968,
    parameter int PTR_W                 = clog2(NUMBER_OF_INPUT_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  clr_i,
    output logic [PTR_W-1:0]      ptr_o,
    output wire  [IMG_BITS-1:0]   img_o
);

    logic [PTR_W-1:0] ptr_q;

    // Word pointer: advances on every stored word, returns to 0 on clear.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (rst) begin
            ptr_q <= '0;
        end else if (clr_i) begin
            ptr_q <= '0;
        end else if (wr_en_i) begin
            ptr_q <= ptr_q + PTR_W'(1);
        end
    end

    assign ptr_o = ptr_q;

    for (genvar k = 0; k < NUMBER_OF_INPUT_WORDS; k++) begin : g_word
        localparam int LO = k * DATA_WIDTH;
        localparam int WB = (LO + DATA_WIDTH <= IMG_BITS) ? DATA_WIDTH : IMG_BITS - LO;
        if (LO < IMG_BITS) begin : g_store
            logic [WB-1:0] word_q;

            // Word k of the frame; cleared between frames so short frames pad with 0.
            always_ff @(posedge clk or posedge rst) begin
                // NOTE: this buffer is flop-based and must read as zero for
                // unwritten words, so it is reset and cleared explicitly
                // rather than mapped to a RAM without reset.
                if (rst) begin
                    word_q <= '0;
                end else if (clr_i) begin
                    word_q <= '0;
                end else if (wr_en_i && ptr_q == PTR_W'(k)) begin
                    word_q <= wr_data_i[WB-1:0];
                end
            end

            assign img_o[LO +: WB] = word_q;
        end
    end

endmodule

// File: rtl/axis_nn_frame_wrapper.sv
// AXI4-Stream front end for the cell-based NN classifiers: collects a frame
// into an image buffer, hands it to the core over core_valid/core_ready and
// returns the class as a single-beat packet with backpressure.
// Optional: define AXIS_NN_WATCHDOG_EN to add an EXEC timeout that returns
// class 0 with m_axis_user[USER_TMO] set.
module axis_nn_frame_wrapper
    import axis_nn_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int OUT_WIDTH             = 4,
    parameter int NUMBER_OF_INPUT_WORDS = 32,
    parameter int IMG_BITS              = 968,
    parameter int TIMEOUT_CYCLES        = 4096
) (
    input  logic                  axi_clk,
    input  logic                  rst,
    axis_nn_frame_wrapper_if.slave axis,
    output logic [IMG_BITS-1:0]   core_img,
    output logic                  core_valid,
    input  logic                  core_ready,
    input  logic [OUT_WIDTH-1:0]  core_number,
    output logic [15:0]           frame_count
);

    localparam int PTR_W = clog2(NUMBER_OF_INPUT_WORDS + 1);

    logic [4:0]           state_q, state_d;
    logic [OUT_WIDTH-1:0] res_q, res_d;
    logic [1:0]           user_q, user_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 buf_wr, buf_clr;
    logic [PTR_W-1:0]     ptr;
    logic                 beat;

    axis_nn_frame_buffer #(
        .DATA_WIDTH            (DATA_WIDTH),
        .NUMBER_OF_INPUT_WORDS (NUMBER_OF_INPUT_WORDS),
        .IMG_BITS              (IMG_BITS),
        .PTR_W                 (PTR_W)
    ) u_buf (
        .clk       (axi_clk),
        .rst       (rst),
        .wr_en_i   (buf_wr),
        .wr_data_i (axis.s_axis_data),
        .clr_i     (buf_clr),
        .ptr_o     (ptr),
        .img_o     (core_img)
    );

    // Input is open while collecting or draining; held low during reset so no
    // beat is taken while the block is aborting.
    assign axis.s_axis_ready = !rst && (|(state_q & (ST_IDLE | ST_LOAD | ST_DRAIN)));
    assign beat              = axis.s_axis_valid && axis.s_axis_ready;

`ifdef AXIS_NN_WATCHDOG_EN
    localparam int WD_W = clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_q;
    logic            wdog_expired;

    // Counts EXEC cycles; restarts from 0 every time EXEC is entered.
    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else if (state_q == ST_EXEC) begin
            wdog_q <= wdog_q + WD_W'(1);
        end else begin
            wdog_q <= '0;
        end
    end

    assign wdog_expired = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state logic for the frame FSM, result register and counters.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        res_d   = res_q;
        user_d  = user_q;
        cnt_d   = cnt_q;
        buf_wr  = 1'b0;
        buf_clr = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (beat) begin
                    buf_wr = 1'b1;
                    if (axis.s_axis_last) begin
                        state_d = ST_EXEC;
                    end else if (ptr == PTR_W'(NUMBER_OF_INPUT_WORDS - 1)) begin
                        state_d          = ST_DRAIN;
                        user_d[USER_OVF] = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat && axis.s_axis_last) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (core_ready) begin
                    res_d   = core_number;
                    state_d = ST_SEND;
                end
`ifdef AXIS_NN_WATCHDOG_EN
                else if (wdog_expired) begin
                    res_d            = '0;
                    user_d[USER_TMO] = 1'b1;
                    state_d          = ST_SEND;
                end
`endif
            end
            ST_SEND: begin
                if (axis.m_axis_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    user_d  = '0;
                    res_d   = '0;
                    buf_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, held result beat, flags and frame counter.
    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            user_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            user_q  <= user_d;
            cnt_q   <= cnt_d;
        end
    end

    assign core_valid        = (state_q == ST_EXEC);
    assign axis.m_axis_valid = (state_q == ST_SEND);
    assign axis.m_axis_last  = (state_q == ST_SEND);
    assign axis.m_axis_data  = res_q;
    assign axis.m_axis_user  = user_q;
    assign frame_count       = cnt_q;

endmodule
